pc_unit: RTL and testbench

- Parametrised program-counter unit; successor to the single-register PC, generalised in width, reset/trap vectors and instruction step.
- Sits at the head of the IF stage and owns next-PC selection: sequential, taken branch, jump, call/return, and trap redirect.
- Adds a run-control FSM (IDLE/RUN/HALT) and a small circular return-address stack (RAS) for call/ret prediction.

---
 rtl/pc_unit.sv | 143 ++++++++++++++
 tb/tb_pc_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection, IDLE/RUN/HALT run control and a
// circular return-address stack for call/return prediction.
module pc_unit #(
    parameter int unsigned             XLEN         = 32,
    parameter logic [XLEN-1:0]         RESET_VECTOR = '0,
    parameter logic [XLEN-1:0]         TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int unsigned             INSN_BYTES   = 4,
    parameter int unsigned             RAS_DEPTH    = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            halt_i,
    input  logic            stall_i,
    input  logic            trap_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    input  logic            call_i,
    input  logic            ret_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic [1:0]      state_o,
    output logic            ras_empty_o,
    output logic            ras_overflow_o
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSN_BYTES) - XLEN'(1));
    localparam logic [XLEN-1:0] TRAP_ALIGNED = TRAP_VECTOR & ALIGN_MASK;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   pc_seq;
    logic [PTR_W-1:0]  top_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q;
    logic [XLEN-1:0]   ras_mem [RAS_DEPTH];
    logic [XLEN-1:0]   ras_top;
    logic              ras_nonempty;
    logic              do_push, do_pop, do_replace;

    assign pc_seq       = pc_q + XLEN'(INSN_BYTES);
    assign ras_top      = ras_mem[top_q];
    assign ras_nonempty = (cnt_q != '0);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        do_replace = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (trap_i) begin
                    pc_d = TRAP_ALIGNED;
                end else if (stall_i) begin
                    pc_d = pc_q;
                end else if (halt_i) begin
                    state_d = ST_HALT;
                end else if (branch_taken_i) begin
                    pc_d = branch_target_i & ALIGN_MASK;
                end else if (jump_i) begin
                    if (call_i && ret_i) begin
                        // Swap: return through the top entry and overwrite it with our own link.
                        pc_d       = (ras_nonempty ? ras_top : jump_target_i) & ALIGN_MASK;
                        do_replace = 1'b1;
                    end else if (call_i) begin
                        pc_d    = jump_target_i & ALIGN_MASK;
                        do_push = 1'b1;
                    end else if (ret_i && ras_nonempty) begin
                        pc_d   = ras_top & ALIGN_MASK;
                        do_pop = 1'b1;
                    end else begin
                        pc_d = jump_target_i & ALIGN_MASK;
                    end
                end else begin
                    pc_d = pc_seq;
                end
            end
            ST_HALT: begin
                if (trap_i) begin
                    state_d = ST_RUN;
                    pc_d    = TRAP_ALIGNED;
                end else if (start_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = RESET_VECTOR;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_VECTOR;
            top_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (do_push) begin
                top_q <= top_q + PTR_W'(1);
                if (cnt_q == CNT_FULL) ovf_q <= 1'b1;
                else                   cnt_q <= cnt_q + CNT_W'(1);
            end else if (do_pop) begin
                top_q <= top_q - PTR_W'(1);
                cnt_q <= cnt_q - CNT_W'(1);
            end else if (do_replace && !ras_nonempty) begin
                cnt_q <= CNT_W'(1);
            end
        end
    end

    // Stack storage carries no reset; entries beyond the count are never read.
    always_ff @(posedge clk_i) begin
        if (do_push)         ras_mem[top_q + PTR_W'(1)] <= pc_seq;
        else if (do_replace) ras_mem[top_q]             <= pc_seq;
    end

    assign pc_o           = pc_q;
    assign state_o        = state_q;
    assign pc_valid_o     = (state_q == ST_RUN) && !stall_i;
    assign ras_empty_o    = !ras_nonempty;
    assign ras_overflow_o = ovf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus queues hand-computed expectations,
// a monitor process compares them against the DUT outputs each cycle.
module tb_pc_unit;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i, halt_i, stall_i, trap_i;
    logic        branch_taken_i, jump_i, call_i, ret_i;
    logic [31:0] branch_target_i, jump_target_i;
    logic [31:0] pc_o;
    logic        pc_valid_o, ras_empty_o, ras_overflow_o;
    logic [1:0]  state_o;

    pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100),
              .INSN_BYTES(4), .RAS_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .halt_i(halt_i),
        .stall_i(stall_i), .trap_i(trap_i), .branch_taken_i(branch_taken_i),
        .branch_target_i(branch_target_i), .jump_i(jump_i),
        .jump_target_i(jump_target_i), .call_i(call_i), .ret_i(ret_i),
        .pc_o(pc_o), .pc_valid_o(pc_valid_o), .state_o(state_o),
        .ras_empty_o(ras_empty_o), .ras_overflow_o(ras_overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [1:0]  st;
        logic        v, e, o;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, HALT = 2'b10;

    task automatic chk(input string nm, input logic [31:0] pc, input logic [1:0] st,
                       input logic v, input logic e, input logic o);
        exp_t x;
        x.name = nm; x.pc = pc; x.st = st; x.v = v; x.e = e; x.o = o;
        exp_q.push_back(x);
    endtask

    task automatic nxt();
        @(negedge clk_i);
        start_i = 0; halt_i = 0; stall_i = 0; trap_i = 0;
        branch_taken_i = 0; jump_i = 0; call_i = 0; ret_i = 0;
        branch_target_i = '0; jump_target_i = '0;
    endtask

    task automatic jmp(input logic [31:0] t, input logic c, input logic r);
        jump_i = 1; jump_target_i = t; call_i = c; ret_i = r;
    endtask

    // Monitor: inputs settle at the falling edge, outputs are sampled 2 time units later.
    initial begin
        forever begin
            @(negedge clk_i);
            #2;
            while (exp_q.size() > 0) begin
                exp_t x;
                x = exp_q.pop_front();
                n_cmp++;
                if ({pc_o, state_o, pc_valid_o, ras_empty_o, ras_overflow_o} !==
                    {x.pc, x.st, x.v, x.e, x.o}) begin
                    n_bad++;
                    $display("FAIL %s: got pc=%h st=%b valid=%b empty=%b ovf=%b, want pc=%h st=%b valid=%b empty=%b ovf=%b",
                             x.name, pc_o, state_o, pc_valid_o, ras_empty_o, ras_overflow_o,
                             x.pc, x.st, x.v, x.e, x.o);
                end
            end
        end
    end

    initial begin
        rst_i = 1;
        nxt(); nxt();
        rst_i = 0;                       chk("reset", 32'h0, IDLE, 0, 1, 0);
        nxt();                           chk("idle2", 32'h0, IDLE, 0, 1, 0);
        nxt(); start_i = 1;              chk("start", 32'h0, IDLE, 0, 1, 0);
        nxt();                           chk("run_first", 32'h0, RUN, 1, 1, 0);
        for (int k = 1; k <= 8; k++) begin
            nxt();
            if (k == 8) stall_i = 1;
            chk("seq", 32'(4 * k), RUN, (k != 8), 1, 0);
        end
        // stall window at 0x20 with trap on the second stall cycle
        nxt(); stall_i = 1; trap_i = 1;  chk("stall2", 32'h20, RUN, 0, 1, 0);
        nxt(); stall_i = 1;              chk("trap_over_stall", 32'h100, RUN, 0, 1, 0);
        nxt();                           chk("stall_release", 32'h100, RUN, 1, 1, 0);
        nxt(); jmp(32'h40, 0, 0);        chk("pre_jump", 32'h104, RUN, 1, 1, 0);
        nxt(); jmp(32'h200, 1, 0);
        branch_taken_i = 1; branch_target_i = 32'h80;
                                         chk("jump_0x40", 32'h40, RUN, 1, 1, 0);
        nxt(); jmp(32'h10, 0, 0);        chk("branch_wins", 32'h80, RUN, 1, 1, 0);
        nxt(); jmp(32'h300, 1, 0);       chk("at_0x10", 32'h10, RUN, 1, 1, 0);
        nxt(); jmp(32'hDEAD_BEEC, 0, 1); chk("call_0x300", 32'h300, RUN, 1, 0, 0);
        nxt(); jmp(32'hDEAD_BEEC, 0, 1); chk("ret_pop", 32'h14, RUN, 1, 1, 0);
        nxt(); jmp(32'h0, 0, 0);         chk("ret_empty", 32'hDEAD_BEEC, RUN, 1, 1, 0);
        // five nested calls overflow a four-deep stack
        nxt(); jmp(32'h100, 1, 0);       chk("call1", 32'h0, RUN, 1, 1, 0);
        nxt(); jmp(32'h200, 1, 0);       chk("call2", 32'h100, RUN, 1, 0, 0);
        nxt(); jmp(32'h300, 1, 0);       chk("call3", 32'h200, RUN, 1, 0, 0);
        nxt(); jmp(32'h400, 1, 0);       chk("call4", 32'h300, RUN, 1, 0, 0);
        nxt(); jmp(32'h500, 1, 0);       chk("call5", 32'h400, RUN, 1, 0, 0);
        nxt(); jmp(32'hBAD0, 0, 1);      chk("overflow", 32'h500, RUN, 1, 0, 1);
        nxt(); jmp(32'hBAD0, 0, 1);      chk("ret1", 32'h404, RUN, 1, 0, 1);
        nxt(); jmp(32'hBAD0, 0, 1);      chk("ret2", 32'h304, RUN, 1, 0, 1);
        nxt(); jmp(32'hBAD0, 0, 1);      chk("ret3", 32'h204, RUN, 1, 0, 1);
        nxt(); jmp(32'h600, 1, 1);       chk("ret4_empty", 32'h104, RUN, 1, 1, 1);
        nxt(); jmp(32'h700, 0, 1);       chk("callret_empty", 32'h600, RUN, 1, 0, 1);
        nxt(); call_i = 1;               chk("ret_link", 32'h108, RUN, 1, 1, 1);
        nxt(); jmp(32'hFFFF_FFFF, 0, 0); chk("call_no_jump", 32'h10C, RUN, 1, 1, 1);
        nxt();                           chk("aligned_top", 32'hFFFF_FFFC, RUN, 1, 1, 1);
        nxt(); halt_i = 1;               chk("wrap", 32'h0, RUN, 1, 1, 1);
        nxt();                           chk("halt1", 32'h0, HALT, 0, 1, 1);
        nxt();                           chk("halt2", 32'h0, HALT, 0, 1, 1);
        nxt(); start_i = 1;              chk("halt3", 32'h0, HALT, 0, 1, 1);
        nxt();                           chk("resume", 32'h0, RUN, 1, 1, 1);
        nxt(); stall_i = 1; halt_i = 1;  chk("resume_adv", 32'h4, RUN, 0, 1, 1);
        nxt(); halt_i = 1;               chk("stall_blocks_halt", 32'h4, RUN, 1, 1, 1);
        nxt(); trap_i = 1;               chk("halt_again", 32'h4, HALT, 0, 1, 1);
        nxt();                           chk("wake_on_trap", 32'h100, RUN, 1, 1, 1);
        nxt();                           chk("run_after_wake", 32'h104, RUN, 1, 1, 1);
        // no clock edge separates this reset from the sample
        nxt(); rst_i = 1; stall_i = 1;   chk("async_reset", 32'h0, IDLE, 0, 1, 0);
        nxt(); rst_i = 0; trap_i = 1; jmp(32'h500, 0, 0); start_i = 0;
                                         chk("post_reset", 32'h0, IDLE, 0, 1, 0);
        nxt();                           chk("idle_ignores", 32'h0, IDLE, 0, 1, 0);
        nxt(); nxt();
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
